// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, addresses instruction_memory and presents
// fetched words to decode through a valid/ready output register with branch redirects.
module instruction_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_address,
    input  logic [31:0]           imem_instruction,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [31:0]           if_instruction,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [ADDR_WIDTH-1:0] if_pc_plus4,
    output logic                  fault
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAULT} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_valid;
    logic [31:0]           r_instr;
    logic [ADDR_WIDTH-1:0] r_if_pc;
    logic [ADDR_WIDTH-1:0] r_if_pc4;
    logic                  r_fault;

    logic                  w_load;
    logic                  w_misaligned;
    logic [ADDR_WIDTH-1:0] w_pc_inc;

    assign w_load       = !r_valid || if_ready;
    assign w_misaligned = |branch_target[1:0];
    assign w_pc_inc     = r_pc + ADDR_WIDTH'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_valid  <= 1'b0;
            r_instr  <= '0;
            r_if_pc  <= '0;
            r_if_pc4 <= ADDR_WIDTH'(4);
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_RUN;
                S_RUN: begin
                    // Redirect wins over load; a concurrent handshake simply drains the output.
                    if (branch_taken) begin
                        r_valid <= 1'b0;
                        if (w_misaligned) begin
                            r_state <= S_FAULT;
                            r_fault <= 1'b1;
                        end else begin
                            r_pc <= branch_target;
                        end
                    end else if (w_load) begin
                        r_instr  <= imem_instruction;
                        r_if_pc  <= r_pc;
                        r_if_pc4 <= w_pc_inc;
                        r_valid  <= 1'b1;
                        r_pc     <= w_pc_inc;
                    end
                end
                default: r_state <= S_FAULT;
            endcase
        end
    end

    assign imem_address   = r_pc;
    assign if_valid       = r_valid;
    assign if_instruction = r_instr;
    assign if_pc          = r_if_pc;
    assign if_pc_plus4    = r_if_pc4;
    assign fault          = r_fault;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a transaction-level model checked every cycle against
// two instances (reset PC 0 and a wrap-around reset PC) plus hand-computed literals.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a_addr, a_imem, a_tgt, a_ins, a_pc, a_pc4;
    logic        a_bt, a_rdy, a_v, a_f;
    logic [31:0] b_addr, b_imem, b_ins, b_pc, b_pc4;
    logic        b_v, b_f;
    logic        b_bt  = 1'b0;
    logic        b_rdy = 1'b1;
    logic [31:0] b_tgt = 32'h0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h2008_0005;
            32'h4:   return 32'h2009_0003;
            32'h8:   return 32'h0109_5020;
            default: return {a[15:0] ^ 16'h5A5A, a[31:16]};
        endcase
    endfunction

    assign a_imem = mem(a_addr);
    assign b_imem = mem(b_addr);

    instruction_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'h0)) dut_a (
        .clk(clk), .rst_n(rst_n), .imem_address(a_addr), .imem_instruction(a_imem),
        .branch_taken(a_bt), .branch_target(a_tgt), .if_valid(a_v), .if_ready(a_rdy),
        .if_instruction(a_ins), .if_pc(a_pc), .if_pc_plus4(a_pc4), .fault(a_f));

    instruction_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk(clk), .rst_n(rst_n), .imem_address(b_addr), .imem_instruction(b_imem),
        .branch_taken(b_bt), .branch_target(b_tgt), .if_valid(b_v), .if_ready(b_rdy),
        .if_instruction(b_ins), .if_pc(b_pc), .if_pc_plus4(b_pc4), .fault(b_f));

    // Model: phase 0 = just out of reset, 1 = fetching, 2 = dead after bad redirect.
    typedef struct {
        int          phase;
        logic [31:0] pc;
        logic        v;
        logic [31:0] ins;
        logic [31:0] ipc;
        logic [31:0] ip4;
        logic        f;
    } model_t;

    model_t ma, mb;

    function automatic model_t m_reset(input logic [31:0] rpc);
        model_t s;
        s.phase = 0; s.pc = rpc; s.v = 1'b0; s.ins = 32'h0;
        s.ipc = 32'h0; s.ip4 = 32'h4; s.f = 1'b0;
        return s;
    endfunction

    function automatic model_t m_step(input model_t s, input logic bt,
                                      input logic [31:0] tgt, input logic rdy);
        model_t n = s;
        if (s.phase == 0) n.phase = 1;
        else if (s.phase == 1) begin
            if (bt && (tgt % 4 != 0)) begin
                n.phase = 2; n.f = 1'b1; n.v = 1'b0;
            end else if (bt) begin
                n.pc = tgt; n.v = 1'b0;
            end else if (!s.v || rdy) begin
                n.ins = mem(s.pc); n.ipc = s.pc; n.ip4 = s.pc + 32'd4;
                n.pc = s.pc + 32'd4; n.v = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma = m_reset(32'h0);
            mb = m_reset(32'hFFFF_FFF8);
        end else begin
            ma = m_step(ma, a_bt, a_tgt, a_rdy);
            mb = m_step(mb, b_bt, b_tgt, b_rdy);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("a_addr", a_addr, ma.pc);   chk("a_valid", {31'b0, a_v}, {31'b0, ma.v});
        chk("a_ins", a_ins, ma.ins);    chk("a_pc", a_pc, ma.ipc);
        chk("a_pc4", a_pc4, ma.ip4);    chk("a_fault", {31'b0, a_f}, {31'b0, ma.f});
        chk("b_addr", b_addr, mb.pc);   chk("b_valid", {31'b0, b_v}, {31'b0, mb.v});
        chk("b_ins", b_ins, mb.ins);    chk("b_pc", b_pc, mb.ipc);
        chk("b_pc4", b_pc4, mb.ip4);    chk("b_fault", {31'b0, b_f}, {31'b0, mb.f});
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; a_bt = 1'b0; a_tgt = 32'h0; a_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick;
        chk("idle_valid", {31'b0, a_v}, 32'h0);
        chk("idle_addr", a_addr, 32'h0);
        tick;
        chk("first_valid", {31'b0, a_v}, 32'h1);
        chk("first_pc", a_pc, 32'h0);
        chk("first_ins", a_ins, 32'h2008_0005);
        chk("wrap_pc_f8", b_pc, 32'hFFFF_FFF8);
        tick;
        chk("second_pc", a_pc, 32'h4);
        chk("second_ins", a_ins, 32'h2009_0003);
        chk("wrap_pc_fc", b_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4_fc", b_pc4, 32'h0);
        a_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("bp_pc", a_pc, 32'h4);
            chk("bp_ins", a_ins, 32'h2009_0003);
            chk("bp_addr", a_addr, 32'h8);
            if (i == 0) chk("wrap_pc_0", b_pc, 32'h0);
        end
        a_rdy = 1'b1;
        tick;
        chk("third_pc", a_pc, 32'h8);
        chk("third_ins", a_ins, 32'h0109_5020);
        a_bt = 1'b1; a_tgt = 32'h28;
        tick;
        a_bt = 1'b0;
        chk("redir_bubble", {31'b0, a_v}, 32'h0);
        chk("redir_addr", a_addr, 32'h28);
        tick;
        chk("redir_valid", {31'b0, a_v}, 32'h1);
        chk("redir_pc", a_pc, 32'h28);
        chk("redir_pc4", a_pc4, 32'h2C);
        a_bt = 1'b1; a_tgt = 32'h2A;
        tick;
        chk("fault_set", {31'b0, a_f}, 32'h1);
        chk("fault_valid", {31'b0, a_v}, 32'h0);
        chk("fault_addr", a_addr, 32'h2C);
        for (int i = 0; i < 10; i++) begin
            a_bt = 1'($urandom); a_tgt = $urandom; a_rdy = 1'($urandom);
            tick;
            chk("fault_hold", {31'b0, a_f}, 32'h1);
            chk("fault_pc_frozen", a_addr, 32'h2C);
        end
        a_bt = 1'b0; a_rdy = 1'b1; rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        tick;
        chk("restart_pc", a_pc, 32'h0);
        a_rdy = 1'b0;
        tick;
        chk("stall_valid", {31'b0, a_v}, 32'h1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", {31'b0, a_v}, 32'h0);
        chk("async_ins", a_ins, 32'h0);
        chk("async_pc", a_pc, 32'h0);
        chk("async_pc4", a_pc4, 32'h4);
        chk("async_addr", a_addr, 32'h0);
        chk("async_fault", {31'b0, a_f}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1; a_rdy = 1'b1;
        tick;
        chk("rst_idle_valid", {31'b0, a_v}, 32'h0);
        tick;
        chk("rst_first_pc", a_pc, 32'h0);
        chk("rst_first_ins", a_ins, 32'h2008_0005);
        repeat (4) tick;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Drives the address side of instruction_memory and presents fetched instructions to decode through a valid/ready handshake. Holds the PC register, increments it by 4 per accepted fetch, and takes branch/jump redirects from execute. Sits between instruction_memory (combinational read) and the decode stage.

Parameters:
ADDR_WIDTH, 32, width of PC and memory address
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
imem_address  output  ADDR_WIDTH  address driven to instruction_memory; equals pc register
imem_instruction  input  32  instruction word returned combinationally by instruction_memory
branch_taken  input  1  one-cycle redirect request from execute
branch_target  input  ADDR_WIDTH  redirect PC, sampled when branch_taken=1
if_valid  output  1  output register holds a valid instruction
if_ready  input  1  decode accepts the output this cycle
if_instruction  output  32  fetched instruction
if_pc  output  ADDR_WIDTH  PC of if_instruction
if_pc_plus4  output  ADDR_WIDTH  if_pc + 4, modulo 2^ADDR_WIDTH
fault  output  1  misaligned redirect detected; sticky until reset

Behaviour:
- Reset (rst_n=0, asynchronous): pc=RESET_PC, state=IDLE, if_valid=0, if_instruction=0, if_pc=0, if_pc_plus4=4, fault=0.
- imem_address = pc at all times (combinational from register).
- FSM states: IDLE, RUN, FAULT.
- IDLE: exactly one cycle after reset release; if_valid stays 0, pc held; next state RUN.
- RUN, load condition: load = (!if_valid || if_ready). On load at edge: if_instruction<=imem_instruction, if_pc<=pc, if_pc_plus4<=pc+4, if_valid<=1, pc<=pc+4.
- RUN, no load (if_valid=1, if_ready=0): all outputs and pc held; back-pressure held indefinitely without loss.
- Throughput: one instruction per cycle while if_ready=1. Latency: address presented in cycle N -> if_valid with that instruction in cycle N+1.
- Redirect (RUN, branch_taken=1, branch_target[1:0]=0): priority over load; pc<=branch_target, if_valid<=0 (flush). A handshake on the same cycle (if_valid && if_ready) still completes: the current output is consumed, nothing else. Target instruction appears with if_valid=1 the cycle after the redirect (one bubble).
- Misaligned redirect (branch_target[1:0]!=0): next state FAULT, fault<=1, if_valid<=0, pc held. FAULT ignores all inputs until rst_n=0.
- branch_taken in IDLE is ignored.
- Wrap-around: pc=32'hFFFF_FFFC -> next pc 0; if_pc_plus4 for that fetch = 0.
- Reset mid-operation: immediate return to reset values regardless of state or pending handshake.
- No X on outputs after reset; imem_instruction only sampled on load.

Test Plan:
- Reset then if_ready=1 with memory words 0x20080005, 0x20090003, 0x01095020 at 0/4/8 -> if_valid rises cycle 2 after release; if_pc 0,4,8 with those words on consecutive cycles.
- Back-pressure: if_ready=0 for 3 cycles while if_pc=4 -> if_instruction/if_pc/imem_address (8) held constant; on if_ready=1 next output if_pc=8, no skipped or duplicated PC.
- Redirect: branch_taken=1, target=0x28 while if_pc=8 and if_ready=1 -> next cycle if_valid=0, imem_address=0x28; following cycle if_pc=0x28, if_pc_plus4=0x2C, if_valid=1.
- Misaligned redirect target=0x2A -> fault=1 next cycle, if_valid=0, pc frozen; remains so for 10 cycles with any branch_taken/if_ready activity.
- Wrap: RESET_PC=32'hFFFF_FFF8 -> if_pc sequence FFFFFFF8, FFFFFFFC, 00000000; if_pc_plus4 for FFFFFFFC equals 0.
- Reset asserted mid-stream (if_valid=1, if_ready=0) -> outputs go to reset values asynchronously before next edge; fetch restarts at RESET_PC after IDLE.
